conv_window_engine: RTL

//  Parametrised, clocked 2-D valid convolution of an NxN signed image with a KxK signed filter.

---
 rtl/conv_window_engine.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/conv_window_engine.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_engine
// Purpose  : Clocked 2-D valid convolution of an NxN signed image with a KxK
//            signed filter. Output positions are walked row-major with a
//            configurable stride, one MAC per cycle. Each output pixel is
//            shifted right by FRAC, saturated to DW bits and emitted on a
//            valid/ready stream.
// Ports    : clk        rising-edge clock
//            reset      synchronous, active-low reset
//            start      begin a frame (honoured only in IDLE or DONE)
//            image      N*N signed pixels, pixel r*N+c at [(r*N+c)*DW +: DW]
//            filter     K*K signed taps, tap u*K+v at [(u*K+v)*DW +: DW]
//            out_data   signed result for (out_row, out_col)
//            out_valid  out_data/out_row/out_col valid
//            out_ready  consumer accepts when out_valid & out_ready
//            out_row    output row index
//            out_col    output column index
//            busy       high while a frame is in progress
//            done       level-high once all M*M results were accepted
// Options  : CONV_ENGINE_RELU_EN - clamp negative results to zero
// Revision : 1.0 - initial release
// ============================================================================
module conv_window_engine #(
  parameter int N      = 10,
  parameter int K      = 5,
  parameter int STRIDE = 1,
  parameter int DW     = 16,
  parameter int FRAC   = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [N*N*DW-1:0]                    image,
  input  logic [K*K*DW-1:0]                    filter,
  output logic [DW-1:0]                        out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [$clog2((N-K)/STRIDE+1):0]      out_row,
  output logic [$clog2((N-K)/STRIDE+1):0]      out_col,
  output logic                                 busy,
  output logic                                 done
);

  localparam int c_m    = (N - K) / STRIDE + 1;
  localparam int c_accw = 2 * DW + $clog2(K * K);
  localparam int c_rw   = $clog2(c_m) + 1;
  localparam int c_tw   = $clog2(K) + 1;
  localparam int c_iw   = $clog2(N * N) + 1;
  localparam int c_fw   = $clog2(K * K) + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MAC  = 3'd1,
    S_FIN  = 3'd2,
    S_OUT  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                   r_state;
  logic [c_rw-1:0]          r_row;
  logic [c_rw-1:0]          r_col;
  logic [c_tw-1:0]          r_u;
  logic [c_tw-1:0]          r_v;
  logic signed [c_accw-1:0] r_acc;

  logic [c_iw-1:0]          w_pix_idx;
  logic [c_fw-1:0]          w_tap_idx;
  logic signed [DW-1:0]     w_pix;
  logic signed [DW-1:0]     w_tap;
  logic signed [2*DW-1:0]   w_prod;
  logic signed [c_accw-1:0] w_shift;
  logic [c_accw-DW:0]       w_hi;
  logic [DW-1:0]            w_res;

  // Window tap addressing and scaled, saturated result
  always_comb begin
    w_pix_idx = c_iw'((32'(r_row) * STRIDE + 32'(r_u)) * N + 32'(r_col) * STRIDE + 32'(r_v));
    w_tap_idx = c_fw'(32'(r_u) * K + 32'(r_v));
    w_pix     = image[32'(w_pix_idx) * DW +: DW];
    w_tap     = filter[32'(w_tap_idx) * DW +: DW];
    w_prod    = w_pix * w_tap;
    w_shift   = r_acc >>> FRAC;
    // The value fits in DW bits when every bit above the DW-bit sign is a copy of it
    w_hi      = w_shift[c_accw-1:DW-1];
    if ((&w_hi) || !(|w_hi)) begin
      w_res = w_shift[DW-1:0];
    end else if (w_shift[c_accw-1]) begin
      w_res = {1'b1, {(DW-1){1'b0}}};
    end else begin
      w_res = {1'b0, {(DW-1){1'b1}}};
    end
`ifdef CONV_ENGINE_RELU_EN
    if (w_res[DW-1]) begin
      w_res = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_row     <= '0;
      r_col     <= '0;
      r_u       <= '0;
      r_v       <= '0;
      r_acc     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_MAC;
            r_row   <= '0;
            r_col   <= '0;
            r_u     <= '0;
            r_v     <= '0;
            r_acc   <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + c_accw'(w_prod);
          if (r_v == c_tw'(K - 1)) begin
            r_v <= '0;
            if (r_u == c_tw'(K - 1)) begin
              r_u     <= '0;
              r_state <= S_FIN;
            end else begin
              r_u <= r_u + c_tw'(1);
            end
          end else begin
            r_v <= r_v + c_tw'(1);
          end
        end
        S_FIN: begin
          out_data  <= w_res;
          out_row   <= r_row;
          out_col   <= r_col;
          out_valid <= 1'b1;
          r_state   <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_acc     <= '0;
            r_u       <= '0;
            r_v       <= '0;
            if (r_col == c_rw'(c_m - 1)) begin
              if (r_row == c_rw'(c_m - 1)) begin
                r_state <= S_DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                r_row   <= r_row + c_rw'(1);
                r_col   <= '0;
                r_state <= S_MAC;
              end
            end else begin
              r_col   <= r_col + c_rw'(1);
              r_state <= S_MAC;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
